vx_issue_scoreboard: RTL
========================

Name: vx_issue_scoreboard

Overview:
- Consumer end of the instruction-buffer dequeue interface.
- Accepts one decoded instruction per cycle from the per-warp instruction buffer and holds it in a single-entry issue stage.
- Tracks pending register writes per warp in a scoreboard and releases an instruction to the execute dispatch only when it has no RAW or WAW hazard.
- Writeback commits clear scoreboard entries. A stall watchdog flags suspected deadlock.

Parameters:
- NUM_WARPS, 4, number of warps; NW_BITS = max(1, clog2(NUM_WARPS)).
- NUM_REGS, 64, architectural registers per warp (int+fp); NR_BITS = clog2(NUM_REGS).
- DATAW, 128, opaque instruction payload width (tmask, PC, op fields, imm).
- STALL_LIMIT, 1023, consecutive hazard-stall cycles before stall_timeout asserts; counter width clog2(STALL_LIMIT+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ibuf_valid  in  1  instruction from buffer valid
- ibuf_ready  out  1  issue stage can accept
- ibuf_wid  in  NW_BITS  warp id
- ibuf_wb  in  1  instruction writes rd
- ibuf_rd  in  NR_BITS  destination register
- ibuf_used_regs  in  NUM_REGS  one-hot-or source/dest register mask
- ibuf_data  in  DATAW  payload
- iss_valid  out  1  hazard-free instruction available
- iss_ready  in  1  dispatch accepts
- iss_wid  out  NW_BITS  warp id of issued instruction
- iss_data  out  DATAW  payload of issued instruction
- wb_valid  in  1  writeback commit
- wb_wid  in  NW_BITS  writeback warp
- wb_rd  in  NR_BITS  writeback register
- wb_eop  in  1  last packet of the writeback; only then release
- stall_timeout  out  1  sticky deadlock flag

Behaviour:
- Reset values:
  - stage_valid=0, so iss_valid=0.
  - All scoreboard bits 0.
  - Stall counter 0; stall_timeout 0.
  - iss_wid/iss_data are don't-care (registers need no reset).
- Stage fields (wid, wb, rd, used_regs, data) load on ibuf fire. ibuf_fire = ibuf_valid && ibuf_ready.
- ibuf_ready = !stage_valid || iss_fire, with iss_fire = iss_valid && iss_ready. This gives full throughput (1 instr/cycle) with no bubble when hazard-free.
- Latency: an instruction accepted at cycle N can present iss_valid at N+1 at the earliest.
- Hazard: hazard = |(stage_used_regs & inuse_eff[stage_wid]).
  - used_regs includes rd when wb=1, so one check covers RAW and WAW.
  - iss_valid = stage_valid && !hazard.
  - iss_wid/iss_data come directly from stage registers.
- Holding: iss_data/iss_wid stay stable while iss_valid=1 and iss_ready=0. The stage is not overwritten until iss_fire.
- Set: on iss_fire with stage_wb=1 and stage_rd!=0, set inuse[stage_wid][stage_rd] next cycle.
- Register 0 is never set, so it is never a hazard source.
- Clear: on wb_valid && wb_eop, clear inuse[wb_wid][wb_rd] next cycle. wb_valid without eop changes nothing.
- Same-bit set and clear in one cycle: set wins. This can only arise with bypass.
- Clear of an already-clear bit: no effect, no error.
- Stall counter:
  - Increments each cycle with stage_valid && hazard.
  - Resets to 0 on any cycle without hazard stall.
  - Saturates at STALL_LIMIT.
- stall_timeout asserts the cycle after the counter reaches STALL_LIMIT. It stays set until reset.
- Back-pressure (iss_ready=0 with no hazard) does not count as a stall.
- Reset mid-operation: the staged instruction is dropped and all pending bits are lost. Upstream must also be reset.

Optional Feature:
- Macro: VX_SCOREBOARD_BYPASS_EN.
- Defined: inuse_eff = inuse with the current cycle's release bit (wb_valid && wb_eop) masked off. A dependent instruction can issue in the same cycle as its producer's final writeback.
- Undefined: inuse_eff = inuse (registered only). The dependent instruction issues no earlier than the cycle after the writeback.
- Both modes obey the set-wins rule.

Test Plan:
- Back-to-back independent instructions: warp0 writes x5, then x6, with iss_ready=1 -> iss_valid on consecutive cycles with ibuf_ready held 1. Afterwards inuse[0] = bits 5 and 6.
- RAW stall: issue warp1 wb rd=7, then warp1 with used_regs bit7 -> iss_valid=0 until wb_valid/eop wid=1 rd=7.
  - Bypass off: issue one cycle after the writeback.
  - Bypass on: issue in the same cycle.
- Multi-packet writeback: wb_valid wid=1 rd=7 with eop=0 for 3 cycles, then eop=1 -> dependent instruction stays stalled until the eop cycle rules apply.
- Cross-warp independence: warp2 pending x9, warp3 reads x9 -> warp3 issues immediately; rd=0 writes are never tracked.
- Back-pressure: iss_ready=0 for 5 cycles with a hazard-free instruction -> iss_data/iss_wid stable, ibuf_ready=0, stall counter stays 0, single issue on release.
- Watchdog: STALL_LIMIT=15 with a permanent hazard -> stall_timeout=1 after 16 stall cycles and remains 1 after the hazard clears. Reset clears it to 0 and empties the scoreboard.

Source files
------------

// File: rtl/vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : vx_issue_scoreboard
// Brief    : Single-entry issue stage with per-warp register scoreboard and
//            stall watchdog. Optional macro VX_SCOREBOARD_BYPASS_EN enables
//            same-cycle writeback release bypass.
// Revision : 1.0 - initial release
// ============================================================================
module vx_issue_scoreboard #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 64,
    parameter int DATAW       = 128,
    parameter int STALL_LIMIT = 1023,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NR_BITS    = $clog2(NUM_REGS),
    localparam int CNT_W      = $clog2(STALL_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ibuf_valid,
    output logic                ibuf_ready,
    input  logic [NW_BITS-1:0]  ibuf_wid,
    input  logic                ibuf_wb,
    input  logic [NR_BITS-1:0]  ibuf_rd,
    input  logic [NUM_REGS-1:0] ibuf_used_regs,
    input  logic [DATAW-1:0]    ibuf_data,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [NW_BITS-1:0]  iss_wid,
    output logic [DATAW-1:0]    iss_data,
    input  logic                wb_valid,
    input  logic [NW_BITS-1:0]  wb_wid,
    input  logic [NR_BITS-1:0]  wb_rd,
    input  logic                wb_eop,
    output logic                stall_timeout
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STALL_LIMIT);

    logic                               r_stage_valid;
    logic [NW_BITS-1:0]                 r_wid;
    logic                               r_wb;
    logic [NR_BITS-1:0]                 r_rd;
    logic [NUM_REGS-1:0]                r_used;
    logic [DATAW-1:0]                   r_data;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_inuse;
    logic [CNT_W-1:0]                   r_stall_cnt;
    logic                               r_timeout;

    logic                w_ibuf_fire;
    logic                w_iss_fire;
    logic                w_release;
    logic                w_set;
    logic [NUM_REGS-1:0] w_rel_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_inuse_eff;
    logic                w_hazard;
    logic                w_stall;

    assign w_release  = wb_valid && wb_eop;
    assign w_rel_mask = w_release ? (NUM_REGS'(1) << wb_rd) : '0;
    assign w_set      = w_iss_fire && r_wb && (r_rd != '0);
    assign w_set_mask = w_set ? (NUM_REGS'(1) << r_rd) : '0;

    always_comb begin
        w_inuse_eff = r_inuse[r_wid];
`ifdef VX_SCOREBOARD_BYPASS_EN
        // Final writeback this cycle releases its register to the waiting instruction.
        if (wb_wid == r_wid) begin
            w_inuse_eff = r_inuse[r_wid] & ~w_rel_mask;
        end
`endif
    end

    assign w_hazard    = |(r_used & w_inuse_eff);
    assign iss_valid   = r_stage_valid && !w_hazard;
    assign w_iss_fire  = iss_valid && iss_ready;
    assign ibuf_ready  = !r_stage_valid || w_iss_fire;
    assign w_ibuf_fire = ibuf_valid && ibuf_ready;
    assign w_stall     = r_stage_valid && w_hazard;

    assign iss_wid       = r_wid;
    assign iss_data      = r_data;
    assign stall_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
        end else if (w_ibuf_fire) begin
            r_stage_valid <= 1'b1;
        end else if (w_iss_fire) begin
            r_stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ibuf_fire) begin
            r_wid  <= ibuf_wid;
            r_wb   <= ibuf_wb;
            r_rd   <= ibuf_rd;
            r_used <= ibuf_used_regs;
            r_data <= ibuf_data;
        end
    end

    // Clear applied before set so a same-bit collision leaves the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inuse <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_inuse[w] <= (r_inuse[w] & ~((wb_wid == NW_BITS'(w)) ? w_rel_mask : '0))
                            | ((r_wid == NW_BITS'(w)) ? w_set_mask : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != C_LIMIT) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (r_stall_cnt == C_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
